// File: rtl/cpu_pkg.sv
// Shared definitions for the hardwired control unit: opcodes, ALU selects,
// sequencer state encoding and IR field positions.
package cpu_pkg;

  localparam int OP_MSB = 31;
  localparam int OP_LSB = 27;
  localparam int RA_MSB = 26;
  localparam int RA_LSB = 23;
  localparam int RB_MSB = 22;
  localparam int RB_LSB = 19;
  localparam int RC_MSB = 18;
  localparam int RC_LSB = 15;

  localparam logic [4:0] OP_ADD  = 5'b00000;
  localparam logic [4:0] OP_SUB  = 5'b00001;
  localparam logic [4:0] OP_AND  = 5'b00010;
  localparam logic [4:0] OP_OR   = 5'b00011;
  localparam logic [4:0] OP_SHR  = 5'b00100;
  localparam logic [4:0] OP_SHRA = 5'b00101;
  localparam logic [4:0] OP_SHL  = 5'b00110;
  localparam logic [4:0] OP_ROR  = 5'b00111;
  localparam logic [4:0] OP_ROL  = 5'b01000;
  localparam logic [4:0] OP_MUL  = 5'b01111;
  localparam logic [4:0] OP_DIV  = 5'b10000;
  localparam logic [4:0] OP_HALT = 5'b11011;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_SHL  = 4'd4;
  localparam logic [3:0] ALU_SHR  = 4'd5;
  localparam logic [3:0] ALU_SHRA = 4'd6;
  localparam logic [3:0] ALU_ROL  = 4'd7;
  localparam logic [3:0] ALU_ROR  = 4'd8;
  localparam logic [3:0] ALU_MUL  = 4'd9;
  localparam logic [3:0] ALU_DIV  = 4'd10;

  typedef enum logic [3:0] {
    S_IDLE, S_T0, S_T1, S_T1W, S_T2, S_DEC,
    S_T3, S_T4, S_T5, S_T6, S_HALT, S_FAULT
  } state_t;

  typedef struct packed {
    logic       legal;   // executable through T3..T5/T6 (HALT is not)
    logic       muldiv;  // 64-bit result, needs the T6 HI write-back
    logic [3:0] alu_op;
  } op_info_t;

  function automatic op_info_t decode_op(input logic [4:0] op);
    op_info_t info;
    info = '{legal: 1'b1, muldiv: 1'b0, alu_op: ALU_ADD};
    case (op)
      OP_ADD:  info.alu_op = ALU_ADD;
      OP_SUB:  info.alu_op = ALU_SUB;
      OP_AND:  info.alu_op = ALU_AND;
      OP_OR:   info.alu_op = ALU_OR;
      OP_SHR:  info.alu_op = ALU_SHR;
      OP_SHRA: info.alu_op = ALU_SHRA;
      OP_SHL:  info.alu_op = ALU_SHL;
      OP_ROR:  info.alu_op = ALU_ROR;
      OP_ROL:  info.alu_op = ALU_ROL;
      OP_MUL:  begin info.alu_op = ALU_MUL; info.muldiv = 1'b1; end
      OP_DIV:  begin info.alu_op = ALU_DIV; info.muldiv = 1'b1; end
      default: info.legal = 1'b0;
    endcase
    return info;
  endfunction

endpackage

// File: rtl/reg_field_decoder.sv
// Turns a 4-bit IR register field into a one-hot register strobe bus.
module reg_field_decoder #(
  parameter int NUM_REGS = 16
) (
  input  logic                en,
  input  logic [3:0]          field,
  output logic [NUM_REGS-1:0] onehot
);

  always_comb begin
    onehot = '0;
    if (en && (int'(field) < NUM_REGS)) onehot[field] = 1'b1;
  end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired Moore control unit: fetch (T0-T2, T1W stall), decode, and execute
// (T3-T6) of register ALU, MUL/DIV and HALT instructions on the single-bus datapath.
module control_sequencer
  import cpu_pkg::*;
#(
  parameter int NUM_REGS  = 16,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clock,
  input  logic                 clear,
  input  logic                 run,
  input  logic                 mem_ready,
  input  logic [31:0]          ir,
  output logic [NUM_REGS-1:0]  Rin,
  output logic [NUM_REGS-1:0]  Rout,
  output logic                 PCin,
  output logic                 PCout,
  output logic                 MARin,
  output logic                 MDRin,
  output logic                 MDRout,
  output logic                 IRin,
  output logic                 Yin,
  output logic                 IncPC,
  output logic                 Read,
  output logic                 Zlowin,
  output logic                 Zhighin,
  output logic                 Zlowout,
  output logic                 Zhighout,
  output logic                 HIin,
  output logic                 LOin,
  output logic [3:0]           ALUop,
  output logic                 halted,
  output logic                 illegal,
  output logic [CNT_WIDTH-1:0] instr_count,
  output logic [3:0]           state
);

  state_t   state_q, state_d;
  op_info_t info;
  logic     retire;
  logic     rin_en, rout_en;
  logic [3:0] rout_field;
  logic     unused_ir_bits;

  assign info           = decode_op(ir[OP_MSB:OP_LSB]);
  assign unused_ir_bits = ^ir[RC_LSB-1:0];

  // NOTE: state and counter use non-blocking assignments so every register
  // samples pre-edge values; clear is synchronous, checked inside the clocked block.
  always_ff @(posedge clock) begin
    if (clear) begin
      state_q     <= S_IDLE;
      instr_count <= '0;
    end else begin
      state_q <= state_d;
      if (retire) instr_count <= instr_count + CNT_WIDTH'(1);
    end
  end

  // NOTE: every output and next-state term gets a default first so no path
  // through the case statement can infer a latch.
  always_comb begin
    state_d    = state_q;
    retire     = 1'b0;
    rin_en     = 1'b0;
    rout_en    = 1'b0;
    rout_field = ir[RB_MSB:RB_LSB];
    PCin = 1'b0; PCout = 1'b0; MARin = 1'b0; MDRin = 1'b0; MDRout = 1'b0;
    IRin = 1'b0; Yin = 1'b0; IncPC = 1'b0; Read = 1'b0;
    Zlowin = 1'b0; Zhighin = 1'b0; Zlowout = 1'b0; Zhighout = 1'b0;
    HIin = 1'b0; LOin = 1'b0;
    ALUop = ALU_ADD;

    case (state_q)
      S_IDLE: if (run) state_d = S_T0;
      S_T0: begin
        PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zlowin = 1'b1;
        state_d = S_T1;
      end
      S_T1: begin
        Zlowout = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = 1'b1;
        state_d = mem_ready ? S_T2 : S_T1W;
      end
      // PC was already written back in T1; only keep re-latching MDR.
      S_T1W: begin
        Read = 1'b1; MDRin = 1'b1;
        if (mem_ready) state_d = S_T2;
      end
      S_T2: begin
        MDRout = 1'b1; IRin = 1'b1;
        state_d = S_DEC;
      end
      S_DEC: begin
        if (ir[OP_MSB:OP_LSB] == OP_HALT) state_d = S_HALT;
        else if (!info.legal)             state_d = S_FAULT;
        else                              state_d = S_T3;
      end
      S_T3: begin
        rout_en = 1'b1; Yin = 1'b1;
        state_d = S_T4;
      end
      S_T4: begin
        rout_en = 1'b1; rout_field = ir[RC_MSB:RC_LSB];
        ALUop = info.alu_op; Zlowin = 1'b1; Zhighin = info.muldiv;
        state_d = S_T5;
      end
      S_T5: begin
        Zlowout = 1'b1;
        if (info.muldiv) begin
          LOin    = 1'b1;
          state_d = S_T6;
        end else begin
          rin_en  = 1'b1;
          retire  = 1'b1;
          state_d = run ? S_T0 : S_IDLE;
        end
      end
      S_T6: begin
        Zhighout = 1'b1; HIin = 1'b1; retire = 1'b1;
        state_d = run ? S_T0 : S_IDLE;
      end
      S_HALT, S_FAULT: state_d = state_q;
      default:         state_d = S_IDLE;
    endcase
  end

  reg_field_decoder #(.NUM_REGS(NUM_REGS)) u_rin_dec (
    .en(rin_en), .field(ir[RA_MSB:RA_LSB]), .onehot(Rin)
  );

  reg_field_decoder #(.NUM_REGS(NUM_REGS)) u_rout_dec (
    .en(rout_en), .field(rout_field), .onehot(Rout)
  );

  assign halted  = (state_q == S_HALT);
  assign illegal = (state_q == S_FAULT);
  assign state   = state_q;

endmodule

// File: doc/control_sequencer.md
Name: control_sequencer

Overview:
Hardwired Moore control unit that drives the existing single-bus datapath through fetch (T0–T2) and execute (T3–T6) of register-register ALU instructions, mul/div and halt. It replaces the per-test hand-written state machines in the phase benches. It decodes the IR value fed back from the datapath and emits every datapath strobe. A memory-ready handshake stalls fetch, and the run, halt and illegal controls gate sequencing.

Parameters:
NUM_REGS, 16, width of one-hot Rin/Rout buses (register field is 4 bits)
CNT_WIDTH, 16, width of retired-instruction counter

Ports:
clock  in  1  system clock, all state updates on rising edge
clear  in  1  synchronous, active-high reset
run  in  1  level; permits a new fetch from IDLE
mem_ready  in  1  memory read data valid on Mdatain this cycle
ir  in  32  current IR register contents from datapath
Rin  out  NUM_REGS  one-hot register load
Rout  out  NUM_REGS  one-hot register drive
PCin, PCout, MARin, MDRin, MDRout, IRin, Yin, IncPC, Read  out  1 each  datapath strobes
Zlowin, Zhighin, Zlowout, Zhighout, HIin, LOin  out  1 each  Z/HI/LO strobes
ALUop  out  4  ALU operation select
halted  out  1  high while in HALT
illegal  out  1  high while in FAULT
instr_count  out  CNT_WIDTH  retired instructions
state  out  4  current state encoding (debug)

Behaviour:
- Reset is synchronous:
  - clear high at an edge forces IDLE and sets instr_count=0.
  - This holds from any state, including mid-instruction; no further strobes are issued.
- Outputs are purely combinational from state and ir.
  - All strobes, Rin, Rout and ALUop default to 0 in every state not listed below.
  - In IDLE, HALT and FAULT all strobes are 0.
- IR fields:
  - op = ir[31:27], ra = ir[26:23], rb = ir[22:19], rc = ir[18:15].
  - One-hot Rin/Rout = 1 << field.
- Opcodes:
  - ADD 00000, SUB 00001, AND 00010, OR 00011
  - SHR 00100, SHRA 00101, SHL 00110, ROR 00111, ROL 01000
  - MUL 01111, DIV 10000, HALT 11011
  - All others are illegal.
- ALUop codes: ADD 0, SUB 1, AND 2, OR 3, SHL 4, SHR 5, SHRA 6, ROL 7, ROR 8, MUL 9, DIV 10.
- States and transitions:
  - IDLE: if run goes to T0, else stays.
  - T0: PCout, MARin, IncPC, Zlowin. Goes to T1.
  - T1: Zlowout, PCin, Read, MDRin. Goes to T2 if mem_ready, else to T1W.
  - T1W (wait): Read, MDRin only, with no PC strobes (PC is already updated). Stays until mem_ready, then goes to T2. Each wait cycle re-latches MDR.
  - T2: MDRout, IRin. Goes to DEC.
  - DEC: no strobes; ir now holds the new instruction.
    - op HALT goes to HALT.
    - Illegal op goes to FAULT.
    - Otherwise goes to T3.
  - T3: Rout[rb], Yin. Goes to T4.
  - T4: Rout[rc], ALUop per op, Zlowin; Zhighin also for MUL/DIV. Goes to T5.
  - T5:
    - ALU ops: Zlowout, Rin[ra]; retire.
    - MUL/DIV: Zlowout, LOin; go to T6.
  - T6 (MUL/DIV only): Zhighout, HIin; retire.
  - Retire: instr_count increments (wrapping at 2^CNT_WIDTH-1 to 0). Next state is T0 if run, else IDLE.
  - HALT, FAULT: sticky; only clear exits.
- Exactly one bus driver per state, and at most one Rin bit and one Rout bit set.
- rb==rc is legal, with the same register driven in T3 and T4.
- ra equal to rb or rc is legal, because the write occurs in T5 after the operands are latched.
- Latency:
  - ALU instruction: 7 cycles (T0, T1, T2, DEC, T3, T4, T5) plus one per T1W cycle.
  - MUL/DIV: 8 cycles.
- run deasserting mid-instruction does not abort; it is sampled only in IDLE and at retire.
- mem_ready is ignored outside T1/T1W.

Decomposition:
- Shared package cpu_pkg:
  - opcode localparams
  - ALUop localparams (ALU_ADD..ALU_DIV, including ALU_SHR=5)
  - state encoding
  - IR field bit positions
- One sub-module, reg_field_decoder: 4-bit field to NUM_REGS one-hot with enable. Instantiated twice, for Rin and Rout.

Test Plan:
- shr R7,R0,R4: ir=0x23820000, run=1, mem_ready=1.
  - T3: Rout=0x0001.
  - T4: Rout=0x0010, ALUop=5, Zlowin.
  - T5: Rin=0x0080, Zlowout.
  - instr_count goes 0 to 1 after 7 cycles.
- add R3,R1,R2: ir=0x01890000, with mem_ready low for 3 cycles in T1.
  - Three T1W cycles, each with Read=1 and PCin=0.
  - Retires after 10 cycles; T5 has Rin=0x0008, ALUop=0.
- mul R5,R6: ir=0x782B0000.
  - T4: ALUop=9 with Zlowin and Zhighin both high.
  - T5: LOin with Zlowout.
  - T6: HIin with Zhighout.
  - Rin=0 throughout; 8 cycles total.
- halt:
  - ir=0xD8000000 reaches HALT after DEC, with halted=1.
  - All strobes 0 for 20 cycles.
  - clear returns to IDLE with instr_count=0.
- Illegal op: ir=0xF8000000 reaches FAULT with illegal=1 and no Rin activity.
- clear asserted in T4: next cycle state=IDLE, all outputs 0, instr_count=0.
- Reissue with run held high: two back-to-back instructions, with T0 immediately following T5.
